panic_desc_gen: RTL and testbench

PANIC_DESC_GEN -- requirements
Module: panic_desc_gen

---
 rtl/panic_desc_gen_pkg.sv | 38 +++
 rtl/panic_define.v | 14 +
 rtl/panic_desc_fifo.sv | 63 ++++++
 rtl/panic_desc_gen.sv | 187 ++++++++++++++++++
 tb/tb_panic_desc_gen.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panic_desc_gen_pkg.sv
// panic_desc_gen_pkg
//   Shared types for the descriptor generator: field widths (taken from
//   panic_define.v), the packed descriptor, the FIFO entry layout and a
//   saturating length adder.
`include "panic_define.v"

package panic_desc_gen_pkg;

   localparam int PRIO_W    = `PANIC_DESC_PRIO_SIZE;
   localparam int CHAIN_W   = `PANIC_DESC_CHAIN_SIZE;
   localparam int TIME_W    = `PANIC_DESC_TIME_SIZE;
   localparam int LEN_W     = `PANIC_DESC_LEN_SIZE;
   localparam int FLOW_ID_W = `PANIC_DESC_FLOW_ID_SIZE;
   localparam int DESC_W    = `PANIC_DESC_WIDTH;
   localparam int ENTRY_W   = DESC_W + LEN_W;

   typedef struct packed {
      logic [PRIO_W-1:0]    prio;
      logic [CHAIN_W-1:0]   chain;
      logic [TIME_W-1:0]    tstamp;
      logic [LEN_W-1:0]     pk_len;
      logic [FLOW_ID_W-1:0] flow_id;
   } desc_t;

   typedef struct packed {
      desc_t            desc;
      logic [LEN_W-1:0] byte_cnt;
   } entry_t;

   // Sticks at all-ones instead of wrapping on very long frames.
   function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                    input logic [LEN_W-1:0] b);
      logic [LEN_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
   endfunction

endpackage

// File: rtl/panic_define.v
// Shared descriptor field widths for the PANIC datapath.
// Every block that carries parser descriptors takes its widths from here.
`ifndef PANIC_DEFINE_V
`define PANIC_DEFINE_V

`define PANIC_DESC_PRIO_SIZE     5
`define PANIC_DESC_CHAIN_SIZE    16
`define PANIC_DESC_TIME_SIZE     16
`define PANIC_DESC_LEN_SIZE      16
`define PANIC_DESC_FLOW_ID_SIZE  8

`define PANIC_DESC_WIDTH (`PANIC_DESC_PRIO_SIZE + `PANIC_DESC_CHAIN_SIZE + `PANIC_DESC_TIME_SIZE + `PANIC_DESC_LEN_SIZE + `PANIC_DESC_FLOW_ID_SIZE)

`endif

// File: rtl/panic_desc_fifo.sv
// panic_desc_fifo
//   Small synchronous FIFO holding finished descriptors.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     push, push_data   write strobe / entry (ignored when full and not popping)
//     pop               read strobe (ignored when empty)
//     pop_data          head entry, zero while empty
//     valid             FIFO not empty
//     count             current occupancy 0..DEPTH
module panic_desc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign valid    = (count != '0);
   assign do_pop   = pop && valid;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
   assign pop_data = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/panic_desc_gen.sv
// panic_desc_gen
//   Watches a frame stream (no backpressure), requests a descriptor from the
//   header parser at each start of frame, measures the frame length from
//   tkeep and queues {descriptor, byte count} for downstream.
//   A frame is only accepted when the FIFO has room at its SOP; otherwise it
//   is dropped whole.
//   Optional build macro: PANIC_DESC_DROP_CNT_EN adds drop_cnt.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     s_axis_*                monitored stream (tdata unused, tkeep counted)
//     desc_req                SOP seen this cycle (combinational)
//     desc_next               descriptor consumed from parser this cycle
//     s_desc_*                parser descriptor fields
//     m_desc_valid/ready      FIFO head handshake
//     m_desc_*                FIFO head fields, m_desc_byte_cnt = frame bytes
//     drop_cnt                refused SOP count (only with the macro)
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | waiting for SOP, any valid beat starts a frame
//   BODY    | inside an accepted frame, counting bytes
//   DROP    | inside a refused frame, waiting for tlast
`include "panic_define.v"

module panic_desc_gen
   import panic_desc_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]               s_axis_tkeep,
   input  logic                                s_axis_tvalid,
   input  logic                                s_axis_tlast,
   output logic                                desc_req,
   output logic                                desc_next,
   input  logic [`PANIC_DESC_PRIO_SIZE-1:0]    s_desc_prio,
   input  logic [`PANIC_DESC_CHAIN_SIZE-1:0]   s_desc_chain,
   input  logic [`PANIC_DESC_TIME_SIZE-1:0]    s_desc_time,
   input  logic [`PANIC_DESC_LEN_SIZE-1:0]     s_desc_pk_len,
   input  logic [`PANIC_DESC_FLOW_ID_SIZE-1:0] s_desc_flow_id,
   output logic                                m_desc_valid,
   input  logic                                m_desc_ready,
   output logic [`PANIC_DESC_PRIO_SIZE-1:0]    m_desc_prio,
   output logic [`PANIC_DESC_CHAIN_SIZE-1:0]   m_desc_chain,
   output logic [`PANIC_DESC_TIME_SIZE-1:0]    m_desc_time,
   output logic [`PANIC_DESC_LEN_SIZE-1:0]     m_desc_pk_len,
   output logic [`PANIC_DESC_FLOW_ID_SIZE-1:0] m_desc_flow_id,
   output logic [`PANIC_DESC_LEN_SIZE-1:0]     m_desc_byte_cnt
`ifdef PANIC_DESC_DROP_CNT_EN
   ,
   output logic [31:0]                         drop_cnt
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BODY = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PC_W  = $clog2(KEEP_WIDTH + 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   desc_t            in_desc;
   desc_t            lat_desc_q;
   logic [LEN_W-1:0] byte_cnt_q;
   logic [LEN_W-1:0] beat_bytes;
   logic [PC_W-1:0]  keep_pop;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_valid;
   logic             sop;
   logic             accept;
   logic             body_beat;
   logic             push;
   logic             pop;
   entry_t           push_entry;
   entry_t           head_entry;
   logic             unused_tdata;

   assign unused_tdata = ^s_axis_tdata;

   assign in_desc = '{prio:    s_desc_prio,
                      chain:   s_desc_chain,
                      tstamp:  s_desc_time,
                      pk_len:  s_desc_pk_len,
                      flow_id: s_desc_flow_id};

   always_comb begin
      keep_pop = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         keep_pop = keep_pop + PC_W'(s_axis_tkeep[i]);
      end
   end

   assign beat_bytes = LEN_W'(keep_pop);

   // Occupancy is checked before any same-cycle pop, so a full FIFO refuses
   // the SOP even if downstream drains an entry on that very edge.
   assign sop       = s_axis_tvalid && (state_q == ST_IDLE);
   assign accept    = sop && (fifo_cnt < CNT_W'(FIFO_DEPTH));
   assign body_beat = s_axis_tvalid && (state_q == ST_BODY);
   assign push      = (accept && s_axis_tlast) || (body_beat && s_axis_tlast);
   assign pop       = fifo_valid && m_desc_ready;

   assign desc_req  = sop;
   assign desc_next = accept;

   // Single-beat frames bypass the latch and push the parser fields directly.
   always_comb begin
      push_entry.desc     = lat_desc_q;
      push_entry.byte_cnt = len_sat_add(byte_cnt_q, beat_bytes);
      if (sop) begin
         push_entry.desc     = in_desc;
         push_entry.byte_cnt = beat_bytes;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid && !s_axis_tlast) state_d = accept ? ST_BODY : ST_DROP;
         end
         ST_BODY, ST_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lat_desc_q <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            lat_desc_q <= in_desc;
            byte_cnt_q <= beat_bytes;
         end else if (body_beat) begin
            byte_cnt_q <= len_sat_add(byte_cnt_q, beat_bytes);
         end
      end
   end

`ifdef PANIC_DESC_DROP_CNT_EN
   logic refuse;
   assign refuse = sop && !accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (refuse && (drop_cnt != 32'hFFFF_FFFF)) begin
         drop_cnt <= drop_cnt + 32'd1;
      end
   end
`else
`endif

   panic_desc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .valid     (fifo_valid),
      .count     (fifo_cnt)
   );

   assign m_desc_valid    = fifo_valid;
   assign m_desc_prio     = head_entry.desc.prio;
   assign m_desc_chain    = head_entry.desc.chain;
   assign m_desc_time     = head_entry.desc.tstamp;
   assign m_desc_pk_len   = head_entry.desc.pk_len;
   assign m_desc_flow_id  = head_entry.desc.flow_id;
   assign m_desc_byte_cnt = head_entry.byte_cnt;

endmodule

// File: tb/tb_panic_desc_gen.sv
module tb_panic_desc_gen;
   import panic_desc_gen_pkg::*;

   localparam int DW = 256;
   localparam int KW = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [DW-1:0]        s_axis_tdata;
   logic [KW-1:0]        s_axis_tkeep;
   logic                 s_axis_tvalid;
   logic                 s_axis_tlast;
   logic                 desc_req;
   logic                 desc_next;
   logic [PRIO_W-1:0]    s_desc_prio;
   logic [CHAIN_W-1:0]   s_desc_chain;
   logic [TIME_W-1:0]    s_desc_time;
   logic [LEN_W-1:0]     s_desc_pk_len;
   logic [FLOW_ID_W-1:0] s_desc_flow_id;
   logic                 m_desc_valid;
   logic                 m_desc_ready;
   logic [PRIO_W-1:0]    m_desc_prio;
   logic [CHAIN_W-1:0]   m_desc_chain;
   logic [TIME_W-1:0]    m_desc_time;
   logic [LEN_W-1:0]     m_desc_pk_len;
   logic [FLOW_ID_W-1:0] m_desc_flow_id;
   logic [LEN_W-1:0]     m_desc_byte_cnt;
`ifdef PANIC_DESC_DROP_CNT_EN
   logic [31:0]          drop_cnt;
`endif

   int tests = 0;
   int fails = 0;

   panic_desc_gen #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tlast    (s_axis_tlast),
      .desc_req        (desc_req),
      .desc_next       (desc_next),
      .s_desc_prio     (s_desc_prio),
      .s_desc_chain    (s_desc_chain),
      .s_desc_time     (s_desc_time),
      .s_desc_pk_len   (s_desc_pk_len),
      .s_desc_flow_id  (s_desc_flow_id),
      .m_desc_valid    (m_desc_valid),
      .m_desc_ready    (m_desc_ready),
      .m_desc_prio     (m_desc_prio),
      .m_desc_chain    (m_desc_chain),
      .m_desc_time     (m_desc_time),
      .m_desc_pk_len   (m_desc_pk_len),
      .m_desc_flow_id  (m_desc_flow_id),
      .m_desc_byte_cnt (m_desc_byte_cnt)
`ifdef PANIC_DESC_DROP_CNT_EN
      ,
      .drop_cnt        (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input logic v, input logic [KW-1:0] keep, input logic last);
      s_axis_tvalid = v;
      s_axis_tkeep  = keep;
      s_axis_tlast  = last;
      s_axis_tdata  = {8{$urandom()}};
   endtask

   task automatic set_desc(input logic [PRIO_W-1:0] p, input logic [CHAIN_W-1:0] c,
                           input logic [TIME_W-1:0] t, input logic [LEN_W-1:0] l,
                           input logic [FLOW_ID_W-1:0] f);
      s_desc_prio    = p;
      s_desc_chain   = c;
      s_desc_time    = t;
      s_desc_pk_len  = l;
      s_desc_flow_id = f;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      m_desc_ready = 1'b0;
      set_beat(1'b0, '0, 1'b0);
      set_desc('0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(m_desc_valid), 64'd0);
      check("rst_prio",  64'(m_desc_prio), 64'd0);
      check("rst_bytes", 64'(m_desc_byte_cnt), 64'd0);
      check("rst_req",   64'(desc_req), 64'd0);
`ifdef PANIC_DESC_DROP_CNT_EN
      check("rst_drop",  64'(drop_cnt), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // single-beat frame, 16 bytes
      @(negedge clk);
      set_beat(1'b1, 32'h0000_FFFF, 1'b1);
      set_desc(5'd20, 16'h1234, 16'h0042, 16'd16, 8'd0);
      #1;
      check("a_req",  64'(desc_req), 64'd1);
      check("a_next", 64'(desc_next), 64'd1);
      @(posedge clk); #1;
      check("a_valid", 64'(m_desc_valid), 64'd1);
      check("a_prio",  64'(m_desc_prio), 64'd20);
      check("a_bytes", 64'(m_desc_byte_cnt), 64'd16);
      check("a_chain", 64'(m_desc_chain), 64'h1234);
      check("a_time",  64'(m_desc_time), 64'h42);
      check("a_pklen", 64'(m_desc_pk_len), 64'd16);
      check("a_flow",  64'(m_desc_flow_id), 64'd0);
      @(negedge clk);
      set_beat(1'b0, '0, 1'b0);
      m_desc_ready = 1'b1;
      @(posedge clk); #1;
      check("a_pop", 64'(m_desc_valid), 64'd0);
      @(negedge clk);
      m_desc_ready = 1'b0;

      // 3-beat frame: 32 + 32 + 8 = 72 bytes, parser fields latched at SOP
      @(negedge clk);
      set_beat(1'b1, 32'hFFFF_FFFF, 1'b0);
      set_desc(5'd3, 16'hBEEF, 16'h0100, 16'd72, 8'hAB);
      #1;
      check("b_req1",  64'(desc_req), 64'd1);
      check("b_next1", 64'(desc_next), 64'd1);
      @(negedge clk);
      set_beat(1'b1, 32'hFFFF_FFFF, 1'b0);
      set_desc(5'd9, 16'h0, 16'h0, 16'h0, 8'h0);
      #1;
      check("b_req2",  64'(desc_req), 64'd0);
      check("b_next2", 64'(desc_next), 64'd0);
      @(negedge clk);
      set_beat(1'b1, 32'h0000_00FF, 1'b1);
      #1;
      check("b_next3", 64'(desc_next), 64'd0);
      @(posedge clk); #1;
      check("b_valid", 64'(m_desc_valid), 64'd1);
      check("b_bytes", 64'(m_desc_byte_cnt), 64'd72);
      check("b_prio",  64'(m_desc_prio), 64'd3);
      check("b_flow",  64'(m_desc_flow_id), 64'hAB);
      check("b_chain", 64'(m_desc_chain), 64'hBEEF);
      @(negedge clk);
      set_beat(1'b0, '0, 1'b0);
      m_desc_ready = 1'b1;
      @(posedge clk); #1;
      check("b_pop", 64'(m_desc_valid), 64'd0);
      @(negedge clk);
      m_desc_ready = 1'b0;

      // fill the FIFO with four frames of 1..4 bytes, prio 1..4
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_beat(1'b1, KW'((64'd1 << (i + 1)) - 64'd1), 1'b1);
         set_desc(PRIO_W'(i + 1), CHAIN_W'(i), TIME_W'(i), LEN_W'(i + 1), FLOW_ID_W'(i));
         #1;
         check("c_next", 64'(desc_next), 64'd1);
      end
      // fifth frame (two beats) is refused and dropped whole
      @(negedge clk);
      set_beat(1'b1, 32'h0000_000F, 1'b0);
      set_desc(5'd30, 16'hDEAD, 16'hDEAD, 16'd99, 8'hEE);
      #1;
      check("c5_req",  64'(desc_req), 64'd1);
      check("c5_next", 64'(desc_next), 64'd0);
      @(negedge clk);
      set_beat(1'b1, 32'h0000_FFFF, 1'b1);
      #1;
      check("c5_body_req", 64'(desc_req), 64'd0);
      @(posedge clk); #1;
      check("c_head_valid", 64'(m_desc_valid), 64'd1);
      check("c_head_prio",  64'(m_desc_prio), 64'd1);
      check("c_head_bytes", 64'(m_desc_byte_cnt), 64'd1);
`ifdef PANIC_DESC_DROP_CNT_EN
      check("c_drop", 64'(drop_cnt), 64'd1);
`endif

      // full FIFO, pop and SOP on the same edge: SOP refused, pop happens
      @(negedge clk);
      set_beat(1'b1, 32'h0000_0001, 1'b1);
      set_desc(5'd31, 16'h5555, 16'h5555, 16'd1, 8'h55);
      m_desc_ready = 1'b1;
      #1;
      check("d_req",  64'(desc_req), 64'd1);
      check("d_next", 64'(desc_next), 64'd0);
      @(posedge clk); #1;
      check("d_head_prio",  64'(m_desc_prio), 64'd2);
      check("d_head_bytes", 64'(m_desc_byte_cnt), 64'd2);
`ifdef PANIC_DESC_DROP_CNT_EN
      check("d_drop", 64'(drop_cnt), 64'd2);
`endif
      @(negedge clk);
      set_beat(1'b0, '0, 1'b0);
      @(posedge clk); #1;
      check("d_drain3_prio",  64'(m_desc_prio), 64'd3);
      check("d_drain3_bytes", 64'(m_desc_byte_cnt), 64'd3);
      @(posedge clk); #1;
      check("d_drain4_prio",  64'(m_desc_prio), 64'd4);
      check("d_drain4_bytes", 64'(m_desc_byte_cnt), 64'd4);
      @(posedge clk); #1;
      check("d_empty", 64'(m_desc_valid), 64'd0);
      @(negedge clk);
      m_desc_ready = 1'b0;

      // reset in the middle of a 4-beat frame with one descriptor queued
      @(negedge clk);
      set_beat(1'b1, 32'h0000_0007, 1'b1);
      set_desc(5'd7, 16'h0707, 16'h0707, 16'd3, 8'h07);
      @(posedge clk); #1;
      check("e_pre_valid", 64'(m_desc_valid), 64'd1);
      check("e_pre_prio",  64'(m_desc_prio), 64'd7);
      @(negedge clk);
      set_beat(1'b1, 32'hFFFF_FFFF, 1'b0);
      set_desc(5'd12, 16'h0C0C, 16'h0C0C, 16'd128, 8'h0C);
      #1;
      check("e_b1_next", 64'(desc_next), 64'd1);
      @(negedge clk);
      set_beat(1'b1, 32'hFFFF_FFFF, 1'b0);
      rst_n = 1'b0;
      #1;
      check("e_rst_valid", 64'(m_desc_valid), 64'd0);
      check("e_rst_prio",  64'(m_desc_prio), 64'd0);
`ifdef PANIC_DESC_DROP_CNT_EN
      check("e_rst_drop",  64'(drop_cnt), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      set_beat(1'b1, 32'h0000_000F, 1'b0);
      set_desc(5'd11, 16'h0B0B, 16'h0777, 16'd6, 8'h11);
      #1;
      check("e_sop_req",  64'(desc_req), 64'd1);
      check("e_sop_next", 64'(desc_next), 64'd1);
      @(negedge clk);
      set_beat(1'b1, 32'h0000_0003, 1'b1);
      set_desc(5'd0, 16'h0, 16'h0, 16'h0, 8'h0);
      #1;
      check("e_last_req", 64'(desc_req), 64'd0);
      @(posedge clk); #1;
      check("e_valid", 64'(m_desc_valid), 64'd1);
      check("e_prio",  64'(m_desc_prio), 64'd11);
      check("e_bytes", 64'(m_desc_byte_cnt), 64'd6);
      check("e_flow",  64'(m_desc_flow_id), 64'h11);
      check("e_time",  64'(m_desc_time), 64'h0777);
      @(negedge clk);
      set_beat(1'b0, '0, 1'b0);
      m_desc_ready = 1'b1;
      @(posedge clk); #1;
      check("e_empty", 64'(m_desc_valid), 64'd0);
      @(negedge clk);
      m_desc_ready = 1'b0;

      // 8 two-beat frames streamed while ready toggles 0/1 each cycle;
      // frame f carries prio f+10 and 32 + (f+1) bytes
      for (int f = 0; f < 8; f++) begin
         @(negedge clk);
         set_beat(1'b1, 32'hFFFF_FFFF, 1'b0);
         set_desc(PRIO_W'(f + 10), CHAIN_W'(16'hC000 + f), TIME_W'(16'h0200 + f),
                  16'd40, FLOW_ID_W'(8'h30 + f));
         m_desc_ready = 1'b0;
         #1;
         check("f_next", 64'(desc_next), 64'd1);
         if (f > 0) begin
            check("f_stall_prio", 64'(m_desc_prio), 64'(f + 9));
         end
         @(posedge clk); #1;
         if (f > 0) begin
            check("f_hold_valid", 64'(m_desc_valid), 64'd1);
            check("f_hold_prio",  64'(m_desc_prio), 64'(f + 9));
            check("f_hold_bytes", 64'(m_desc_byte_cnt), 64'(32 + f));
            check("f_hold_flow",  64'(m_desc_flow_id), 64'(8'h30 + f - 1));
         end
         @(negedge clk);
         set_beat(1'b1, KW'((64'd1 << (f + 1)) - 64'd1), 1'b1);
         set_desc('0, '0, '0, '0, '0);
         m_desc_ready = 1'b1;
         @(posedge clk); #1;
         check("f_valid", 64'(m_desc_valid), 64'd1);
         check("f_prio",  64'(m_desc_prio), 64'(f + 10));
         check("f_bytes", 64'(m_desc_byte_cnt), 64'(33 + f));
         check("f_flow",  64'(m_desc_flow_id), 64'(8'h30 + f));
         check("f_chain", 64'(m_desc_chain), 64'(16'hC000 + f));
      end
      @(negedge clk);
      set_beat(1'b0, '0, 1'b0);
      @(posedge clk); #1;
      check("f_drain", 64'(m_desc_valid), 64'd0);
      @(negedge clk);
      m_desc_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
